// File: rtl/rng_sample_pool.sv
// rng_sample_pool: repetition-count health test on RNG samples, FWFT pool of passing samples, sticky alarm
// Ports:
//   clk_i, rst_i (sync, active-high)
//   sample_i / sample_valid_i : raw 64-bit samples with one-cycle strobe
//   alarm_clr_i               : leaves ALARM for a fresh warm-up
//   rd_ready_i / rd_valid_o / rd_data_o : reader handshake on the FIFO head
//   fill_o                    : FIFO occupancy
//   alarm_o                   : sticky health-test failure
//   drop_o                    : pulse when a passing sample found the FIFO full
// Optional RNG_POOL_STATS_EN adds stat_accept_o (pushes) and stat_fail_o (RCT failures), saturating.
module rng_sample_pool #(
  parameter int DEPTH      = 8,
  parameter int RCT_CUTOFF = 3,
  parameter int WARMUP_N   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [63:0]                sample_i,
  input  logic                       sample_valid_i,
  input  logic                       alarm_clr_i,
  input  logic                       rd_ready_i,
  output logic [63:0]                rd_data_o,
  output logic                       rd_valid_o,
  output logic [$clog2(DEPTH):0]     fill_o,
  output logic                       alarm_o,
  output logic                       drop_o
`ifdef RNG_POOL_STATS_EN
  ,
  output logic [31:0]                stat_accept_o,
  output logic [15:0]                stat_fail_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int WW = $clog2(WARMUP_N + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  localparam logic [RW-1:0] CUT = RW'(RCT_CUTOFF);
  localparam logic [WW-1:0] WLAST = WW'(WARMUP_N - 1);
  localparam logic [1:0] S_WARMUP = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_ALARM  = 2'd2;
  logic [1:0] state;
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [FW-1:0] fill_nxt;
  logic [RW-1:0] rep_cnt, rep_nxt;
  logic [WW-1:0] warm_cnt;
  logic [63:0] last, head_nxt;
  logic track, fail, pop, push, drop, full, load, warm_last;
  always_comb begin
    track = sample_valid_i && state != S_ALARM;
    rep_nxt = (rep_cnt != '0 && sample_i == last) ? rep_cnt + RW'(1) : RW'(1);
    fail = track && rep_nxt == CUT;
    rd_valid_o = fill_o != '0 && state != S_ALARM;
    pop = rd_valid_o && rd_ready_i;
    full = fill_o == FULL;
    push = track && state == S_RUN && !fail && (!full || pop);
    drop = track && state == S_RUN && !fail && full && !pop;
    rd_nxt = rd_ptr + AW'(pop);
    fill_nxt = fill_o + FW'(push) - FW'(pop);
    head_nxt = (push && wr_ptr == rd_nxt) ? sample_i : mem[rd_nxt];
    load = fill_nxt != '0 && (pop || fill_o == '0);
    warm_last = warm_cnt == WLAST;
  end
  always_ff @(posedge clk_i)
    if (push) mem[wr_ptr] <= sample_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_WARMUP;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_o <= '0;
      rd_data_o <= '0;
      alarm_o <= 1'b0;
      drop_o <= 1'b0;
      warm_cnt <= '0;
      rep_cnt <= '0;
      last <= '0;
    end else begin
      drop_o <= drop;
      if (track) begin
        rep_cnt <= rep_nxt;
        last <= sample_i;
      end
      if (state == S_ALARM) begin
        if (alarm_clr_i) begin
          state <= S_WARMUP;
          alarm_o <= 1'b0;
          warm_cnt <= '0;
          rep_cnt <= '0;
        end
      end else if (fail) begin
        state <= S_ALARM;
        alarm_o <= 1'b1;
        fill_o <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (state == S_WARMUP && sample_valid_i) begin
          warm_cnt <= warm_last ? '0 : warm_cnt + WW'(1);
          state <= warm_last ? S_RUN : S_WARMUP;
        end
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_nxt;
        fill_o <= fill_nxt;
        if (load) rd_data_o <= head_nxt;
      end
    end
  end
`ifdef RNG_POOL_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_accept_o <= '0;
      stat_fail_o <= '0;
    end else begin
      if (push && stat_accept_o != '1) stat_accept_o <= stat_accept_o + 32'd1;
      if (fail && stat_fail_o != '1) stat_fail_o <= stat_fail_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rng_sample_pool.sv
// tb_rng_sample_pool: directed bench for rng_sample_pool with a queue-based reference model
module tb_rng_sample_pool;
  localparam int DEPTH = 8;
  localparam int CUT = 3;
  localparam int WN = 4;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic sample_valid_i = 1'b0;
  logic alarm_clr_i = 1'b0;
  logic rd_ready_i = 1'b0;
  logic [63:0] sample_i = '0;
  logic [63:0] rd_data_o;
  logic rd_valid_o, alarm_o, drop_o;
  logic [3:0] fill_o;
`ifdef RNG_POOL_STATS_EN
  logic [31:0] stat_accept_o;
  logic [15:0] stat_fail_o;
`endif
  rng_sample_pool #(.DEPTH(DEPTH), .RCT_CUTOFF(CUT), .WARMUP_N(WN)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .sample_i(sample_i),
    .sample_valid_i(sample_valid_i),
    .alarm_clr_i(alarm_clr_i),
    .rd_ready_i(rd_ready_i),
    .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o),
    .fill_o(fill_o),
    .alarm_o(alarm_o),
    .drop_o(drop_o)
`ifdef RNG_POOL_STATS_EN
    ,
    .stat_accept_o(stat_accept_o),
    .stat_fail_o(stat_fail_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  logic [63:0] q[$];
  logic [63:0] m_last, m_head;
  bit m_alarm, m_run, m_drop, m_pop, started;
  int m_warm, m_reps;
  always @(posedge clk_i) begin
    if (rst_i) begin
      q.delete();
      m_alarm = 0;
      m_run = 0;
      m_drop = 0;
      m_warm = 0;
      m_reps = 0;
      m_last = '0;
      m_head = '0;
      started = 1;
    end else begin
      m_pop = q.size() > 0 && !m_alarm && rd_ready_i;
      m_drop = 0;
      if (m_alarm) begin
        if (alarm_clr_i) begin
          m_alarm = 0;
          m_run = 0;
          m_warm = 0;
          m_reps = 0;
        end
      end else begin
        if (sample_valid_i) begin
          m_reps = (m_reps > 0 && sample_i == m_last) ? m_reps + 1 : 1;
          m_last = sample_i;
        end
        if (sample_valid_i && m_reps >= CUT) begin
          m_alarm = 1;
          q.delete();
        end else begin
          if (m_pop) void'(q.pop_front());
          if (sample_valid_i && !m_run) begin
            m_warm++;
            if (m_warm == WN) begin
              m_run = 1;
              m_warm = 0;
            end
          end else if (sample_valid_i) begin
            if (q.size() < DEPTH) q.push_back(sample_i);
            else m_drop = 1;
          end
        end
      end
      if (q.size() > 0) m_head = q[0];
    end
  end
  always @(negedge clk_i)
    if (started) begin
      chk("m_rd_valid", 64'(rd_valid_o), 64'(q.size() > 0 && !m_alarm));
      chk("m_rd_data", rd_data_o, m_head);
      chk("m_fill", 64'(fill_o), 64'(q.size()));
      chk("m_alarm", 64'(alarm_o), 64'(m_alarm));
      chk("m_drop", 64'(drop_o), 64'(m_drop));
    end
  task automatic cyc(input logic v, input logic [63:0] s, input logic rdy = 1'b0, input logic clr = 1'b0);
    sample_valid_i = v;
    sample_i = s;
    rd_ready_i = rdy;
    alarm_clr_i = clr;
    @(negedge clk_i);
    sample_valid_i = 1'b0;
    rd_ready_i = 1'b0;
    alarm_clr_i = 1'b0;
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    cyc(1'b0, '0);
    rst_i = 1'b0;
  endtask
  logic [63:0] uq = 64'hF000_0000_0000_0000;
  task automatic warm();
    for (int i = 0; i < WN; i++) begin
      uq = uq + 64'd1;
      cyc(1'b1, uq);
    end
  endtask
  initial begin
    @(negedge clk_i);
    do_reset();
    chk("rst_valid", 64'(rd_valid_o), 0);
    chk("rst_data", rd_data_o, 0);
    chk("rst_fill", 64'(fill_o), 0);
    chk("rst_alarm", 64'(alarm_o), 0);
    chk("rst_drop", 64'(drop_o), 0);
    warm();
    chk("t1_warm_fill", 64'(fill_o), 0);
    chk("t1_warm_valid", 64'(rd_valid_o), 0);
    cyc(1'b1, 64'hAAAA_AAAA_AAAA_AA01);
    chk("t1_valid", 64'(rd_valid_o), 1);
    chk("t1_data", rd_data_o, 64'hAAAA_AAAA_AAAA_AA01);
    cyc(1'b1, 64'hB2, 1'b1);
    chk("t1_pp_fill", 64'(fill_o), 1);
    chk("t1_pp_data", rd_data_o, 64'hB2);
    do_reset();
    warm();
    cyc(1'b1, 64'd5);
    cyc(1'b1, 64'd5);
    cyc(1'b1, 64'd7);
    chk("t2_fill", 64'(fill_o), 3);
    chk("t2_alarm", 64'(alarm_o), 0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_data", rd_data_o, i == 2 ? 64'd7 : 64'd5);
      cyc(1'b0, '0, 1'b1);
    end
    chk("t2_empty", 64'(fill_o), 0);
    chk("t2_hold", rd_data_o, 64'd7);
    do_reset();
    warm();
    cyc(1'b1, 64'd9);
    cyc(1'b1, 64'd9);
    chk("t3_fill2", 64'(fill_o), 2);
    cyc(1'b1, 64'd9);
    chk("t3_alarm", 64'(alarm_o), 1);
    chk("t3_fill0", 64'(fill_o), 0);
    chk("t3_valid", 64'(rd_valid_o), 0);
    cyc(1'b1, 64'h123);
    chk("t3_ignored", 64'(fill_o), 0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t3_clr", 64'(alarm_o), 0);
    warm();
    chk("t3_rewarm", 64'(fill_o), 0);
    cyc(1'b1, 64'h77);
    chk("t3_run_valid", 64'(rd_valid_o), 1);
    chk("t3_run_data", rd_data_o, 64'h77);
    do_reset();
    warm();
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'h40 + 64'(i));
    chk("t4_full", 64'(fill_o), 8);
    chk("t4_nodrop", 64'(drop_o), 0);
    cyc(1'b1, 64'h48);
    chk("t4_drop", 64'(drop_o), 1);
    chk("t4_fill", 64'(fill_o), 8);
    cyc(1'b0, '0);
    chk("t4_drop_end", 64'(drop_o), 0);
    for (int i = 0; i < 8; i++) begin
      chk("t4_order", rd_data_o, 64'h40 + 64'(i));
      cyc(1'b0, '0, 1'b1);
    end
    chk("t4_empty", 64'(rd_valid_o), 0);
    do_reset();
    warm();
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'h50 + 64'(i));
    cyc(1'b1, 64'h99, 1'b1);
    chk("t5_fill", 64'(fill_o), 8);
    chk("t5_nodrop", 64'(drop_o), 0);
    for (int i = 0; i < 8; i++) begin
      chk("t5_order", rd_data_o, i == 7 ? 64'h99 : 64'h51 + 64'(i));
      cyc(1'b0, '0, 1'b1);
    end
    do_reset();
    warm();
    for (int i = 0; i < 5; i++) cyc(1'b1, 64'h30 + 64'(i));
    chk("t6_fill5", 64'(fill_o), 5);
    do_reset();
    chk("t6_run_rst_fill", 64'(fill_o), 0);
    chk("t6_run_rst_data", rd_data_o, 0);
    warm();
    for (int i = 0; i < 3; i++) cyc(1'b1, 64'h60 + 64'(i));
    cyc(1'b1, 64'h66);
    cyc(1'b1, 64'h66);
    chk("t6_fill", 64'(fill_o), 5);
    cyc(1'b1, 64'h66);
    chk("t6_alarm", 64'(alarm_o), 1);
    chk("t6_held", rd_data_o, 64'h60);
    do_reset();
    chk("t6_rst_alarm", 64'(alarm_o), 0);
    chk("t6_rst_data", rd_data_o, 0);
    chk("t6_rst_fill", 64'(fill_o), 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 64'h70 + 64'(i));
    chk("t6_warm", 64'(fill_o), 0);
    cyc(1'b1, 64'h80);
    chk("t6_run", 64'(fill_o), 1);
    do_reset();
    cyc(1'b1, 64'd3);
    cyc(1'b1, 64'd3);
    cyc(1'b1, 64'd3);
    chk("t7_warm_alarm", 64'(alarm_o), 1);
    cyc(1'b0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
